aes192_round_key_store: RTL
===========================

# aes192_round_key_store

Captures the 13 AES-192 round keys streamed out of the key-expansion stage (`AESKeyexpansion_192`) into a local register file. Replays them to the cipher round datapath over a valid/ready stream, in forward order for encryption or reverse order for decryption. The cipher core can re-run any number of blocks without re-expanding the key.

## Interface
- `NR`, 12: AES-192 round count.
- `NUM_RK`, `NR+1` (13): number of stored round keys.
- `W`, 128: round-key width.

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low; sampled on `clk`
- `key_load`  in  1  pulse; discard stored keys and start a new fill
- `sk_in`  in  W  subkey from key expansion
- `sk_valid`  in  1  `sk_in` valid this cycle
- `key_ready`  out  1  all `NUM_RK` keys captured
- `stream_start`  in  1  pulse; begin replay
- `stream_dec`  in  1  sampled with `stream_start`: 0 = index 0..12, 1 = index 12..0
- `rk_out`  out  W  round key
- `rk_idx`  out  4  index of `rk_out`
- `rk_valid`  out  1  `rk_out` valid
- `rk_last`  out  1  final beat of the stream
- `rk_ready`  in  1  consumer accepts beat
- `busy`  out  1  FILL or STREAM state
- `err`  out  1  one-cycle pulse on a protocol violation

## Operation
- States: EMPTY, FILL, READY, STREAM.
- Reset (`reset`=0 at edge):
  - State goes to EMPTY.
  - Write counter and stream pointer clear.
  - All outputs go to 0.
  - Register-file contents are not reset.
- `key_load`, in any state:
  - Next state is FILL.
  - `key_ready` goes to 0 and the write counter goes to 0.
  - Any active stream aborts: `rk_valid`=0 on the next cycle.
  - If `sk_valid` is also high that cycle, `sk_in` is written as entry 0 and the counter becomes 1.
- FILL:
  - Each `sk_valid` writes `sk_in` to entry[cnt], then cnt++.
  - The write that fills entry 12 moves the state to READY.
- `sk_valid` outside FILL, and not coincident with `key_load`:
  - The data is ignored.
  - `err` pulses.
  - Stored entries are unchanged.
- READY + `stream_start`:
  - Latch `stream_dec`.
  - Pointer = 0 (enc) or 12 (dec).
  - Go to STREAM.
- `stream_start` in EMPTY, FILL or STREAM: ignored, `err` pulses.
- STREAM:
  - `rk_out`/`rk_idx` are registered from entry[ptr].
  - A beat transfers when `rk_valid && rk_ready`.
  - On transfer, the next entry loads the same edge, giving 1 beat/cycle throughput.
  - `rk_last`=1 exactly when `rk_idx`=12 (enc) or 0 (dec).
  - The transfer of the last beat drops `rk_valid`/`rk_last` next cycle and returns to READY.
- Stall: while `rk_valid && !rk_ready`, `rk_out`, `rk_idx` and `rk_last` hold stable.
- `busy` = (state==FILL || state==STREAM).
- Priority, highest first: `reset`, then `key_load`, then the stream/fill logic.

## Timing
- `key_ready` rises on the cycle after the 13th `sk_valid` write.
- A 13-cycle back-to-back fill gives `key_ready` at fill-start +13.
- `rk_valid` rises 1 cycle after an accepted `stream_start`.
- With `rk_ready` held high, 13 consecutive beats.
- `rk_valid` falls 1 cycle after the last transfer.
- `stream_start` in the same cycle as the 13th write: ignored, `err` pulses (state is still FILL).
- A new `stream_start` is accepted no earlier than the cycle after STREAM returns to READY.

## Structure
- Shared package `aes_pkg` holds:
  - `AES192_NR`=12 and `AES192_NUM_RK`=13
  - `rk_t` (128-bit round-key type)
  - the state enum `rks_state_t` (EMPTY/FILL/READY/STREAM)
- Sub-module `aes_rk_regfile`:
  - `NUM_RK`×`W` storage
  - one synchronous write port, one asynchronous read port
- The top level holds the FSM, write counter and stream pointer.

## Test plan
- Fill with FIPS-197 A.2 key 8e73b0f7…62f8ead2522c6b7b, driving 13 back-to-back expansion subkeys:
  - `key_ready`=1 one cycle after the 13th write
  - `busy`=0
- Forward stream, `rk_ready`=1:
  - 13 consecutive beats, `rk_idx` 0..12
  - beat 0 = 8e73b0f7da0e6452c810f32b809079e5
  - beat 1 = 62f8ead2522c6b7bfe0c91f72402f5a5
  - beat 12 = e98ba06f448c773c8ecc720401002202, with `rk_last`=1
- Decrypt stream with `rk_ready` toggling every cycle:
  - first beat `rk_idx`=12 = e98ba06f…01002202, held stable across stalls
  - last beat `rk_idx`=0 with `rk_last`
  - returns to READY
- `key_load` asserted at stream beat 5:
  - `rk_valid`=0 next cycle, `key_ready`=0
  - refill of 13 keys completes normally
- Violations:
  - `stream_start` during FILL → `err` pulse, `rk_valid` stays 0
  - a 14th `sk_valid` in READY → `err` pulse, entry 0 unchanged on the next forward stream
- `reset`=0 for one cycle mid-fill:
  - all outputs 0, state EMPTY
  - a following `stream_start` → `err` pulse, no stream

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-192 round-key constants, types and store FSM states
package aes_pkg;
  localparam int AES192_NR = 12;
  localparam int AES192_NUM_RK = AES192_NR + 1;
  typedef logic [127:0] rk_t;
  typedef enum logic [1:0] {EMPTY, FILL, READY, STREAM} rks_state_t;
endpackage

// File: rtl/aes192_round_key_store_if.sv
// aes192_round_key_store_if: key-fill and round-key replay stream signals
interface aes192_round_key_store_if;
  import aes_pkg::*;
  logic       key_load;
  rk_t        sk_in;
  logic       sk_valid;
  logic       key_ready;
  logic       stream_start;
  logic       stream_dec;
  rk_t        rk_out;
  logic [3:0] rk_idx;
  logic       rk_valid;
  logic       rk_last;
  logic       rk_ready;
  logic       busy;
  logic       err;
  modport master (
    output key_load, sk_in, sk_valid, stream_start, stream_dec, rk_ready,
    input  key_ready, rk_out, rk_idx, rk_valid, rk_last, busy, err
  );
  modport slave (
    input  key_load, sk_in, sk_valid, stream_start, stream_dec, rk_ready,
    output key_ready, rk_out, rk_idx, rk_valid, rk_last, busy, err
  );
endinterface

// File: rtl/aes_rk_regfile.sv
// aes_rk_regfile: round-key storage, one synchronous write port, one asynchronous read port
module aes_rk_regfile
  import aes_pkg::*;
#(
  parameter int NUM_RK = AES192_NUM_RK,
  parameter int W = $bits(rk_t)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(NUM_RK)-1:0] waddr,
  input  logic [W-1:0]              wdata,
  input  logic [$clog2(NUM_RK)-1:0] raddr,
  output logic [W-1:0]              rdata
);
  logic [W-1:0] mem [NUM_RK];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/aes192_round_key_store.sv
// aes192_round_key_store: captures 13 AES-192 round keys and replays them forward or reverse
module aes192_round_key_store
  import aes_pkg::*;
(
  input logic clk,
  input logic reset,
  aes192_round_key_store_if.slave io
);
  rks_state_t state, state_n;
  logic [3:0] cnt, ptr, raddr, waddr, nxt;
  logic dec, dir, we, start, xfer, fill_wr, ld;
  rk_t rdata;
  aes_rk_regfile u_rf (
    .clk(clk), .we(we), .waddr(waddr), .wdata(io.sk_in), .raddr(raddr), .rdata(rdata)
  );
  // ptr always names the next entry to present; raddr swaps to the first entry on start
  always_comb begin
    start = state == READY && io.stream_start;
    xfer = io.rk_valid && io.rk_ready;
    fill_wr = state == FILL && io.sk_valid;
    ld = start || (state == STREAM && xfer && !io.rk_last);
    we = reset && io.sk_valid && (io.key_load || state == FILL);
    waddr = io.key_load ? '0 : cnt;
    dir = start ? io.stream_dec : dec;
    raddr = start ? (io.stream_dec ? 4'(AES192_NR) : '0) : ptr;
    nxt = dir ? raddr - 4'd1 : raddr + 4'd1;
    state_n = io.key_load ? FILL :
              (fill_wr && cnt == 4'(AES192_NR)) ? READY :
              start ? STREAM :
              (state == STREAM && xfer && io.rk_last) ? READY : state;
  end
  assign io.busy = state == FILL || state == STREAM;
  always_ff @(posedge clk)
    if (!reset) state <= EMPTY;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      ptr <= '0;
      dec <= 1'b0;
      io.key_ready <= 1'b0;
      io.rk_out <= '0;
      io.rk_idx <= '0;
      io.rk_valid <= 1'b0;
      io.rk_last <= 1'b0;
      io.err <= 1'b0;
    end else if (io.key_load) begin
      cnt <= {3'b0, io.sk_valid};
      io.key_ready <= 1'b0;
      io.rk_valid <= 1'b0;
      io.rk_last <= 1'b0;
      io.err <= 1'b0;
    end else begin
      io.err <= (io.sk_valid && state != FILL) || (io.stream_start && state != READY);
      if (fill_wr) cnt <= cnt + 4'd1;
      if (fill_wr && cnt == 4'(AES192_NR)) io.key_ready <= 1'b1;
      if (start) dec <= io.stream_dec;
      if (ld) begin
        io.rk_out <= rdata;
        io.rk_idx <= raddr;
        io.rk_valid <= 1'b1;
        io.rk_last <= raddr == (dir ? 4'd0 : 4'(AES192_NR));
        ptr <= nxt;
      end else if (xfer) begin
        io.rk_valid <= 1'b0;
        io.rk_last <= 1'b0;
      end
    end
endmodule
